// File: rtl/switch_debouncer.sv
// Switch input conditioning: per-bit synchronizer, startup capture, then a
// per-bit stability counter that only lets a changed level through once it has held.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             ready
);

  // A single-cycle debounce still needs a 1-bit counter to keep the port widths legal.
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e                             state_q, state_d;
  logic [INIT_W-1:0]                  init_cnt_q, init_cnt_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]                   s_out_q, s_out_d;
  logic [WIDTH-1:0]                   rise_q, rise_d;
  logic [WIDTH-1:0]                   fall_q, fall_d;
  logic                               changed_q, changed_d;
  logic                               ready_q, ready_d;
  logic [WIDTH-1:0]                   s_sync;

  assign s_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = sw_raw;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    s_out_d    = s_out_q;
    ready_d    = ready_q;
    rise_d     = '0;
    fall_d     = '0;

    case (state_q)
      INIT: begin
        // Wait until the synchronizer holds post-reset samples, then adopt them silently.
        if (init_cnt_q == INIT_LAST) begin
          s_out_d = s_sync;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_ONE;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (s_sync[i] == s_out_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            s_out_d[i] = s_sync[i];
            cnt_d[i]   = '0;
            rise_d[i]  = s_sync[i];
            fall_d[i]  = ~s_sync[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      end
      default: state_d = INIT;
    endcase

    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      sync_q     <= '0;
      cnt_q      <= '0;
      s_out_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      changed_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      s_out_q    <= s_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      changed_q  <= changed_d;
      ready_q    <= ready_d;
    end
  end

  assign s_out   = s_out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): directed stimulus
// queues expected update events; a monitor pops one per observed pulse.
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_raw;
  logic [3:0] s_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;
  logic       ready;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_no;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
  } ev_t;

  ev_t exp_q[$];

  switch_debouncer #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .s_out  (s_out),
    .rise   (rise),
    .fall   (fall),
    .changed(changed),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic expect_ev(input int edge_no, input logic [3:0] s, input logic [3:0] r,
                           input logic [3:0] f);
    ev_t e;
    e.edge_no = edge_no;
    e.s       = s;
    e.r       = r;
    e.f       = f;
    exp_q.push_back(e);
  endtask

  task automatic set_sw(input logic [3:0] v);
    @(negedge clk);
    sw_raw = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_out"},   32'(s_out),   32'h0);
    check({tag, "_ready"},   32'(ready),   32'h0);
    check({tag, "_rise"},    32'(rise),    32'h0);
    check({tag, "_fall"},    32'(fall),    32'h0);
    check({tag, "_changed"}, 32'(changed), 32'h0);
  endtask

  // Monitor: any pulse must match the oldest queued event, including its edge number.
  always @(posedge clk) begin
    ev_t e;
    edge_cnt++;
    #1;
    if (reset && (changed || rise != 4'b0 || fall != 4'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: edge %0d s_out=%b rise=%b fall=%b changed=%b, required no pulse",
                 edge_cnt, s_out, rise, fall, changed);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge",    32'(edge_cnt), 32'(e.edge_no));
        check("pulse_s_out",   32'(s_out),    32'(e.s));
        check("pulse_rise",    32'(rise),     32'(e.r));
        check("pulse_fall",    32'(fall),     32'(e.f));
        check("pulse_changed", 32'(changed),  32'h1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1. Startup capture
    reset  = 1'b0;
    sw_raw = 4'b1010;
    wait_cyc(3);
    check_idle_outputs("in_reset");
    reset = 1'b1;
    wait_cyc(2);
    check("init_ready_edge2", 32'(ready), 32'h0);
    check("init_s_out_edge2", 32'(s_out), 32'h0);
    wait_cyc(1);
    check("init_ready_edge3", 32'(ready), 32'h1);
    check("init_s_out_edge3", 32'(s_out), 32'hA);

    // Bring s_out to 0000: bits 3 and 1 fall together
    set_sw(4'b0000);
    n = edge_cnt;
    expect_ev(n + 6, 4'b0000, 4'b0000, 4'b1010);
    wait_cyc(8);

    // 2. Clean rising edge on bit 0
    set_sw(4'b0001);
    n = edge_cnt;
    expect_ev(n + 6, 4'b0001, 4'b0001, 4'b0000);
    wait_cyc(8);
    check("clean_s_out", 32'(s_out), 32'h1);

    // 3a. 3-cycle glitch on bit 1 is rejected
    set_sw(4'b0011);
    wait_cyc(3);
    sw_raw = 4'b0001;
    wait_cyc(8);
    check("glitch3_s_out", 32'(s_out), 32'h1);

    // 3b. 4-cycle pulse on bit 1 passes, then falls back
    set_sw(4'b0011);
    n = edge_cnt;
    expect_ev(n + 6, 4'b0011, 4'b0010, 4'b0000);
    wait_cyc(4);
    sw_raw = 4'b0001;
    expect_ev(n + 10, 4'b0001, 4'b0000, 4'b0010);
    wait_cyc(10);
    check("pulse4_s_out", 32'(s_out), 32'h1);

    // 4. Simultaneous change on two bits
    set_sw(4'b1000);
    n = edge_cnt;
    expect_ev(n + 6, 4'b1000, 4'b1000, 4'b0001);
    wait_cyc(8);
    set_sw(4'b0100);
    n = edge_cnt;
    expect_ev(n + 6, 4'b0100, 4'b0100, 4'b1000);
    wait_cyc(8);

    // 5. Bounce on bit 0, 2-cycle segments, then settle high
    for (int i = 0; i < 6; i++) begin
      set_sw((i % 2 == 0) ? 4'b0101 : 4'b0100);
      wait_cyc(1);
    end
    set_sw(4'b0101);
    n = edge_cnt;
    expect_ev(n + 6, 4'b0101, 4'b0001, 4'b0000);
    wait_cyc(8);
    check("bounce_s_out", 32'(s_out), 32'h5);

    // 6. Reset two edges into a count: clears immediately, then re-captures
    set_sw(4'b0100);
    wait_cyc(3);
    #1;
    reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);
    check("recap_ready_edge2", 32'(ready), 32'h0);
    wait_cyc(1);
    check("recap_ready_edge3", 32'(ready), 32'h1);
    check("recap_s_out_edge3", 32'(s_out), 32'h4);
    wait_cyc(8);
    check("recap_s_out_hold", 32'(s_out), 32'h4);

    check("events_outstanding", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
